// File: rtl/alu_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_muldiv_unit                                                |
// | Purpose  : Execute-stage ALU with registered results, a valid/ready      |
// |            handshake and an iterative multiply/divide engine that owns   |
// |            the architectural HI/LO registers.                            |
// | Config   : `define ALU_DIV_EN compiles in DIV/DIVU and the divider.      |
// |            Without it those opcodes are unmapped (IllegalOp).            |
// | Ports    : Clk, Rst (sync, active-high)                                  |
// |            InValid/InReady   - operation handshake (accept = both high)  |
// |            ALUControl, A, B, Shift - opcode and operands                 |
// |            OutValid          - one-cycle pulse, ALUResult/Zero valid     |
// |            ALUResult, Zero   - registered result and its zero flag       |
// |            Hi, Lo            - architectural HI/LO registers             |
// |            DivByZero, IllegalOp - status pulses qualified by OutValid    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int CTRL_W  = 5
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               InValid,
  output logic               InReady,
  input  logic [CTRL_W-1:0]  ALUControl,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] Shift,
  output logic               OutValid,
  output logic [WIDTH-1:0]   ALUResult,
  output logic               Zero,
  output logic [WIDTH-1:0]   Hi,
  output logic [WIDTH-1:0]   Lo,
  output logic               DivByZero,
  output logic               IllegalOp
);

  localparam logic [CTRL_W-1:0] c_OP_ADD   = CTRL_W'(5'b00000);
  localparam logic [CTRL_W-1:0] c_OP_SUB   = CTRL_W'(5'b00001);
  localparam logic [CTRL_W-1:0] c_OP_MUL   = CTRL_W'(5'b00010);
  localparam logic [CTRL_W-1:0] c_OP_SLT   = CTRL_W'(5'b00011);
  localparam logic [CTRL_W-1:0] c_OP_AND   = CTRL_W'(5'b00100);
  localparam logic [CTRL_W-1:0] c_OP_OR    = CTRL_W'(5'b00101);
  localparam logic [CTRL_W-1:0] c_OP_NOR   = CTRL_W'(5'b00110);
  localparam logic [CTRL_W-1:0] c_OP_XOR   = CTRL_W'(5'b00111);
  localparam logic [CTRL_W-1:0] c_OP_SLL   = CTRL_W'(5'b01000);
  localparam logic [CTRL_W-1:0] c_OP_SRL   = CTRL_W'(5'b01001);
  localparam logic [CTRL_W-1:0] c_OP_SLLV  = CTRL_W'(5'b01010);
  localparam logic [CTRL_W-1:0] c_OP_SRLV  = CTRL_W'(5'b01011);
  localparam logic [CTRL_W-1:0] c_OP_SRA   = CTRL_W'(5'b01100);
  localparam logic [CTRL_W-1:0] c_OP_SRAV  = CTRL_W'(5'b01101);
  localparam logic [CTRL_W-1:0] c_OP_SLTU  = CTRL_W'(5'b01111);
  localparam logic [CTRL_W-1:0] c_OP_MULTU = CTRL_W'(5'b10010);
  localparam logic [CTRL_W-1:0] c_OP_MULT  = CTRL_W'(5'b10011);
  localparam logic [CTRL_W-1:0] c_OP_LUI   = CTRL_W'(5'b10101);
  localparam logic [CTRL_W-1:0] c_OP_MFHI  = CTRL_W'(5'b11000);
  localparam logic [CTRL_W-1:0] c_OP_MFLO  = CTRL_W'(5'b11001);
  localparam logic [CTRL_W-1:0] c_OP_MTHI  = CTRL_W'(5'b11010);
  localparam logic [CTRL_W-1:0] c_OP_MTLO  = CTRL_W'(5'b11011);

  // Which result the engine writes back in DONE.
  localparam logic [1:0] c_K_MUL  = 2'd0;  // low word only, Hi untouched
  localparam logic [1:0] c_K_MULT = 2'd1;  // full double-width product

`ifdef ALU_DIV_EN
  localparam logic [CTRL_W-1:0] c_OP_DIV  = CTRL_W'(5'b10110);
  localparam logic [CTRL_W-1:0] c_OP_DIVU = CTRL_W'(5'b10111);
  localparam logic [1:0]        c_K_DIV   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2,
    S_DIV  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t               r_state;
  logic [SHAMT_W-1:0]   r_count;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_result;
  logic                 r_zero;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_divz;
  logic                 r_illegal;

  // Single-cycle ops are captured at accept and evaluated on the next edge,
  // so a MFHI/MFLO accepted on the DONE edge sees the freshly written HI/LO.
  logic                 r_p_valid;
  logic [CTRL_W-1:0]    r_p_op;
  logic [WIDTH-1:0]     r_p_a;
  logic [WIDTH-1:0]     r_p_b;
  logic [SHAMT_W-1:0]   r_p_sh;

  // Engine: r_acc is the running high half (mul) or partial remainder (div);
  // r_mq holds the multiplier/dividend and shifts in product/quotient bits.
  logic [1:0]           r_kind;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_mq;
  logic [WIDTH-1:0]     r_mcand;
  logic                 r_neg_q;

  logic                 w_accept;
  logic                 w_is_mul;
  logic                 w_op_signed;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_p_res;
  logic                 w_p_ill;

`ifdef ALU_DIV_EN
  logic                 r_neg_r;
  logic                 r_dz;
  logic [WIDTH-1:0]     r_a_orig;
  logic                 w_is_div;
  logic [WIDTH:0]       w_div_sh;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_div_rem;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;
`endif

  assign w_accept = InValid & r_in_ready;
  assign w_is_mul = (ALUControl == c_OP_MUL) || (ALUControl == c_OP_MULT) ||
                    (ALUControl == c_OP_MULTU);
`ifdef ALU_DIV_EN
  assign w_is_div    = (ALUControl == c_OP_DIV) || (ALUControl == c_OP_DIVU);
  assign w_op_signed = (ALUControl == c_OP_MULT) || (ALUControl == c_OP_DIV);
`else
  assign w_op_signed = (ALUControl == c_OP_MULT);
`endif

  // Signed ops run on magnitudes; the sign is restored when the result is written.
  assign w_a_neg = w_op_signed & A[WIDTH-1];
  assign w_b_neg = w_op_signed & B[WIDTH-1];
  assign w_a_mag = w_a_neg ? -A : A;
  assign w_b_mag = w_b_neg ? -B : B;

  // Radix-2 shift-add step: conditionally add, then shift {acc,mq} right.
  assign w_mul_sum = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_mcand} : '0);
  assign w_prod    = r_neg_q ? -{r_acc, r_mq} : {r_acc, r_mq};

`ifdef ALU_DIV_EN
  // Restoring step: shift next dividend bit into the remainder and subtract
  // when it fits. The difference is below the divisor, so WIDTH bits suffice.
  assign w_div_sh  = {r_acc, r_mq[WIDTH-1]};
  assign w_div_ge  = (w_div_sh >= {1'b0, r_mcand});
  assign w_div_rem = w_div_ge ? (w_div_sh[WIDTH-1:0] - r_mcand) : w_div_sh[WIDTH-1:0];
  assign w_quo     = r_neg_q ? -r_mq : r_mq;
  assign w_rem     = r_neg_r ? -r_acc : r_acc;
`endif

  always_comb begin
    w_p_res = '0;
    w_p_ill = 1'b0;
    case (r_p_op)
      c_OP_ADD:  w_p_res = r_p_a + r_p_b;
      c_OP_SUB:  w_p_res = r_p_a - r_p_b;
      c_OP_SLT:  w_p_res = {{(WIDTH-1){1'b0}}, ($signed(r_p_a) < $signed(r_p_b))};
      c_OP_SLTU: w_p_res = {{(WIDTH-1){1'b0}}, (r_p_a < r_p_b)};
      c_OP_AND:  w_p_res = r_p_a & r_p_b;
      c_OP_OR:   w_p_res = r_p_a | r_p_b;
      c_OP_NOR:  w_p_res = ~(r_p_a | r_p_b);
      c_OP_XOR:  w_p_res = r_p_a ^ r_p_b;
      c_OP_SLL:  w_p_res = r_p_b << r_p_sh;
      c_OP_SRL:  w_p_res = r_p_b >> r_p_sh;
      c_OP_SLLV: w_p_res = r_p_b << r_p_a[SHAMT_W-1:0];
      c_OP_SRLV: w_p_res = r_p_b >> r_p_a[SHAMT_W-1:0];
      c_OP_SRA:  w_p_res = $unsigned($signed(r_p_b) >>> r_p_sh);
      c_OP_SRAV: w_p_res = $unsigned($signed(r_p_b) >>> r_p_a[SHAMT_W-1:0]);
      c_OP_LUI:  w_p_res = {r_p_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      c_OP_MFHI: w_p_res = r_hi;
      c_OP_MFLO: w_p_res = r_lo;
      c_OP_MTHI: w_p_res = r_p_a;
      c_OP_MTLO: w_p_res = r_p_a;
      default:   w_p_ill = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_divz      <= 1'b0;
      r_illegal   <= 1'b0;
      r_p_valid   <= 1'b0;
      r_p_op      <= '0;
      r_p_a       <= '0;
      r_p_b       <= '0;
      r_p_sh      <= '0;
      r_kind      <= c_K_MUL;
      r_acc       <= '0;
      r_mq        <= '0;
      r_mcand     <= '0;
      r_neg_q     <= 1'b0;
`ifdef ALU_DIV_EN
      r_neg_r     <= 1'b0;
      r_dz        <= 1'b0;
      r_a_orig    <= '0;
`endif
    end else begin
      r_out_valid <= 1'b0;
      r_divz      <= 1'b0;
      r_illegal   <= 1'b0;
      r_p_valid   <= 1'b0;

      // Single-cycle writeback never coincides with DONE: nothing is
      // accepted on the edge that enters DONE.
      if (r_p_valid) begin
        r_out_valid <= 1'b1;
        r_result    <= w_p_res;
        r_zero      <= (w_p_res == '0);
        r_illegal   <= w_p_ill;
        if (r_p_op == c_OP_MTHI) r_hi <= r_p_a;
        if (r_p_op == c_OP_MTLO) r_lo <= r_p_a;
      end

      case (r_state)
        S_MUL: begin
          r_acc <= w_mul_sum[WIDTH:1];
          r_mq  <= {w_mul_sum[0], r_mq[WIDTH-1:1]};
          if (r_count == '0) begin
            r_state    <= S_DONE;
            r_in_ready <= 1'b1;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
`ifdef ALU_DIV_EN
        S_DIV: begin
          r_acc <= w_div_rem;
          r_mq  <= {r_mq[WIDTH-2:0], w_div_ge};
          if (r_count == '0) begin
            r_state    <= S_DONE;
            r_in_ready <= 1'b1;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
`endif
        S_DONE: begin
          r_out_valid <= 1'b1;
          r_state     <= S_IDLE;
`ifdef ALU_DIV_EN
          if (r_kind == c_K_DIV) begin
            if (r_dz) begin
              r_lo     <= '1;
              r_hi     <= r_a_orig;
              r_result <= '1;
              r_zero   <= 1'b0;
              r_divz   <= 1'b1;
            end else begin
              r_lo     <= w_quo;
              r_hi     <= w_rem;
              r_result <= w_quo;
              r_zero   <= (w_quo == '0);
            end
          end else
`endif
          begin
            r_lo     <= w_prod[WIDTH-1:0];
            r_result <= w_prod[WIDTH-1:0];
            r_zero   <= (w_prod[WIDTH-1:0] == '0);
            if (r_kind == c_K_MULT) r_hi <= w_prod[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase

      // Accept is legal in IDLE and DONE; a new multi-cycle op overrides
      // the DONE -> IDLE transition above.
      if (w_accept) begin
        if (w_is_mul) begin
          r_state    <= S_MUL;
          r_in_ready <= 1'b0;
          r_count    <= SHAMT_W'(WIDTH-1);
          r_kind     <= (ALUControl == c_OP_MUL) ? c_K_MUL : c_K_MULT;
          r_acc      <= '0;
          r_mq       <= w_a_mag;
          r_mcand    <= w_b_mag;
          r_neg_q    <= w_a_neg ^ w_b_neg;
        end
`ifdef ALU_DIV_EN
        else if (w_is_div) begin
          r_state    <= S_DIV;
          r_in_ready <= 1'b0;
          r_count    <= SHAMT_W'(WIDTH-1);
          r_kind     <= c_K_DIV;
          r_acc      <= '0;
          r_mq       <= w_a_mag;
          r_mcand    <= w_b_mag;
          r_neg_q    <= w_a_neg ^ w_b_neg;
          r_neg_r    <= w_a_neg;
          r_dz       <= (B == '0);
          r_a_orig   <= A;
        end
`endif
        else begin
          r_p_valid <= 1'b1;
          r_p_op    <= ALUControl;
          r_p_a     <= A;
          r_p_b     <= B;
          r_p_sh    <= Shift;
        end
      end
    end
  end

  assign InReady   = r_in_ready;
  assign OutValid  = r_out_valid;
  assign ALUResult = r_result;
  assign Zero      = r_zero;
  assign Hi        = r_hi;
  assign Lo        = r_lo;
  assign DivByZero = r_divz;
  assign IllegalOp = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_muldiv_unit                                            |
// | Purpose  : Scoreboard bench for alu_muldiv_unit (WIDTH=32). Directed     |
// |            vectors push hand-computed results; a monitor pops them on    |
// |            every OutValid. DIV vectors follow the ALU_DIV_EN build.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_alu_muldiv_unit;

  localparam logic [4:0] c_ADD = 5'b00000, c_SUB = 5'b00001, c_MUL = 5'b00010;
  localparam logic [4:0] c_SLT = 5'b00011, c_AND = 5'b00100, c_OR = 5'b00101;
  localparam logic [4:0] c_NOR = 5'b00110, c_XOR = 5'b00111, c_SLL = 5'b01000;
  localparam logic [4:0] c_SRL = 5'b01001, c_SLLV = 5'b01010, c_SRLV = 5'b01011;
  localparam logic [4:0] c_SRA = 5'b01100, c_SRAV = 5'b01101, c_BAD = 5'b01110;
  localparam logic [4:0] c_SLTU = 5'b01111, c_MULTU = 5'b10010, c_MULT = 5'b10011;
  localparam logic [4:0] c_LUI = 5'b10101, c_DIV = 5'b10110, c_DIVU = 5'b10111;
  localparam logic [4:0] c_MFHI = 5'b11000, c_MFLO = 5'b11001;
  localparam logic [4:0] c_MTHI = 5'b11010, c_MTLO = 5'b11011;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        InValid = 1'b0;
  logic [4:0]  ALUControl = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [4:0]  Shift = '0;
  logic        InReady, OutValid, Zero, DivByZero, IllegalOp;
  logic [31:0] ALUResult, Hi, Lo;

  alu_muldiv_unit #(.WIDTH(32), .SHAMT_W(5), .CTRL_W(5)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
    .ALUControl(ALUControl), .A(A), .B(B), .Shift(Shift),
    .OutValid(OutValid), .ALUResult(ALUResult), .Zero(Zero),
    .Hi(Hi), .Lo(Lo), .DivByZero(DivByZero), .IllegalOp(IllegalOp)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    string       nm;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        ill;
    int          lat;
    int          t;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endfunction

  // Monitor: every OutValid must match the oldest pending expectation.
  always @(negedge Clk) begin : mon
    exp_t e;
    if (!Rst && OutValid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_outvalid: got ALUResult %h, required no output", ALUResult);
      end else begin
        e = sb.pop_front();
        chk({e.nm, "_result"}, ALUResult, e.res);
        chk({e.nm, "_zero"}, {31'b0, Zero}, {31'b0, (e.res == 32'h0)});
        chk({e.nm, "_hi"}, Hi, e.hi);
        chk({e.nm, "_lo"}, Lo, e.lo);
        chk({e.nm, "_divbyzero"}, {31'b0, DivByZero}, {31'b0, e.dz});
        chk({e.nm, "_illegal"}, {31'b0, IllegalOp}, {31'b0, e.ill});
        chk({e.nm, "_latency"}, cyc - e.t, e.lat);
      end
    end
  end

  // Drive on a negedge and hold until InReady; the accept edge is the next posedge.
  task automatic issue(input string nm, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input logic [31:0] er,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz,
                       input logic eill, input int lat);
    exp_t e;
    int   w;
    @(negedge Clk);
    ALUControl = op; A = a; B = b; Shift = sh; InValid = 1'b1;
    w = 0;
    while (!InReady && w < 200) begin
      @(negedge Clk);
      w++;
    end
    if (!InReady) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_accept_timeout: InReady %0b after %0d cycles, required 1", nm, InReady, w);
    end else begin
      e.nm = nm; e.res = er; e.hi = eh; e.lo = el; e.dz = edz; e.ill = eill;
      e.lat = lat; e.t = cyc + 1;
      sb.push_back(e);
      @(posedge Clk);
    end
    #1 InValid = 1'b0;
  endtask

  initial begin : stim
    int n;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    chk("reset_inready", {31'b0, InReady}, 32'd1);
    chk("reset_outvalid", {31'b0, OutValid}, 32'd0);
    chk("reset_result", ALUResult, 32'h0);
    chk("reset_hi", Hi, 32'h0);
    chk("reset_lo", Lo, 32'h0);
    chk("reset_flags", {30'b0, DivByZero, IllegalOp}, 32'd0);

    // Single-cycle ops, issued back-to-back.
    issue("add",   c_ADD,  32'd5, 32'd7, 5'd0, 32'h0000000C, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    issue("sub",   c_SUB,  32'd3, 32'd5, 5'd0, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    issue("sub0",  c_SUB,  32'd5, 32'd5, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    issue("and",   c_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h00F000F0, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    issue("or",    c_OR,   32'hF0000000, 32'h0000000F, 5'd0, 32'hF000000F, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    issue("nor",   c_NOR,  32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    issue("xor",   c_XOR,  32'hAAAA5555, 32'hFFFF0000, 5'd0, 32'h55555555, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    issue("slt",   c_SLT,  32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    issue("sltu",  c_SLTU, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    issue("sll",   c_SLL,  32'h0, 32'd1, 5'd4, 32'h00000010, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    issue("srl0",  c_SRL,  32'h0, 32'h80000000, 5'd0, 32'h80000000, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    issue("sra31", c_SRA,  32'h0, 32'h80000000, 5'd31, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    issue("srlv",  c_SRLV, 32'h21, 32'h80000000, 5'd0, 32'h40000000, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    issue("sllv",  c_SLLV, 32'd3, 32'd1, 5'd0, 32'h00000008, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    issue("srav",  c_SRAV, 32'd4, 32'hF0000000, 5'd0, 32'hFF000000, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    issue("lui",   c_LUI,  32'h0, 32'hABCD1234, 5'd0, 32'h12340000, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    issue("bad_op", c_BAD, 32'd9, 32'd9, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1);
    issue("mthi",  c_MTHI, 32'h11111111, 32'h0, 5'd0, 32'h11111111, 32'h11111111, 32'h0, 1'b0, 1'b0, 1);
    issue("mtlo",  c_MTLO, 32'h22222222, 32'h0, 5'd0, 32'h22222222, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 1);
    issue("mfhi",  c_MFHI, 32'h0, 32'h0, 5'd0, 32'h11111111, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 1);
    issue("mflo",  c_MFLO, 32'h0, 32'h0, 5'd0, 32'h22222222, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 1);

    // MULT -3*5: InReady low for 32 cycles, MFHI accepted in the DONE cycle.
    issue("mult", c_MULT, 32'hFFFFFFFD, 32'd5, 5'd0, 32'hFFFFFFF1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, 33);
    n = 0;
    while (!InReady && n < 100) begin
      n++;
      @(posedge Clk);
      #1;
    end
    chk("mult_busy_cycles", n, 32);
    issue("mfhi_after_mult", c_MFHI, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, 1);
    issue("multu", c_MULTU, 32'hFFFFFFFF, 32'd2, 5'd0, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFE, 1'b0, 1'b0, 33);
    issue("mul_lo", c_MUL, 32'h00010000, 32'h00010003, 5'd0, 32'h00030000, 32'h1, 32'h00030000, 1'b0, 1'b0, 33);

    // ADD held while MULT is busy: accepted on the DONE edge.
    issue("mult_small", c_MULT, 32'd2, 32'd3, 5'd0, 32'd6, 32'h0, 32'd6, 1'b0, 1'b0, 33);
    issue("add_held", c_ADD, 32'd1, 32'd1, 5'd0, 32'd2, 32'h0, 32'd6, 1'b0, 1'b0, 1);

`ifdef ALU_DIV_EN
    issue("div_7_m2", c_DIV, 32'd7, 32'hFFFFFFFE, 5'd0, 32'hFFFFFFFD, 32'h1, 32'hFFFFFFFD, 1'b0, 1'b0, 33);
    issue("divu_by0", c_DIVU, 32'd9, 32'd0, 5'd0, 32'hFFFFFFFF, 32'd9, 32'hFFFFFFFF, 1'b1, 1'b0, 33);
    issue("div_min_m1", c_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h80000000, 32'h0, 32'h80000000, 1'b0, 1'b0, 33);
    issue("div_m7_2", c_DIV, 32'hFFFFFFF9, 32'd2, 5'd0, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, 33);
`else
    issue("div_nodiv", c_DIV, 32'd7, 32'd2, 5'd0, 32'h0, 32'h0, 32'd6, 1'b0, 1'b1, 1);
    issue("divu_nodiv", c_DIVU, 32'd9, 32'd0, 5'd0, 32'h0, 32'h0, 32'd6, 1'b0, 1'b1, 1);
`endif

    // Let pending results drain before the reset-abort test.
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge Clk);
      n++;
    end

    // Reset asserted mid-MULT (count=10): no OutValid, HI/LO cleared.
    @(negedge Clk);
    ALUControl = c_MULT; A = 32'd7; B = 32'd9; InValid = 1'b1;
    @(posedge Clk);
    #1 InValid = 1'b0;
    repeat (21) @(posedge Clk);
    #1 Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    chk("abort_inready", {31'b0, InReady}, 32'd1);
    chk("abort_outvalid", {31'b0, OutValid}, 32'd0);
    chk("abort_hi", Hi, 32'h0);
    chk("abort_lo", Lo, 32'h0);
    repeat (40) @(negedge Clk);
    issue("add_after_abort", c_ADD, 32'd0, 32'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1);

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
    end
    repeat (2) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
